// File: rtl/mem_responder_if.sv
// +--------------------------------------------------------------------+
// | mem_responder_if : four-phase request/response bus to mem_responder |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

interface mem_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic [1:0]        func;
  logic              execute;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              is_ready;

  modport master (
    output func, execute, address, write_data,
    input  read_data, is_ready
  );

  modport slave (
    input  func, execute, address, write_data,
    output read_data, is_ready
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// +--------------------------------------------------------------------+
// | mem_responder : serves READ/WRITE/ALLOC requests from a sync SRAM   |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_responder #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64,
  parameter int RD_LAT    = 1,
  parameter int FREE_BASE = 128,
  parameter int INIT_CYC  = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  mem_responder_if.slave         bus,
  output logic [ADDR_W-1:0]      free_addr_o,
  output logic                   full_o,
  output logic                   error_o,
  output logic [3:0]             state_o,
  output logic [ADDR_W-1:0]      sram_addr_o,
  output logic [DATA_W-1:0]      sram_wdata_o,
  output logic                   sram_we_o,
  input  wire logic [DATA_W-1:0] sram_rdata_i
);
  typedef enum logic [3:0] {
    S_INIT    = 4'd0,
    S_IDLE    = 4'd1,
    S_RD_WAIT = 4'd2,
    S_WR      = 4'd3,
    S_DONE    = 4'd4
  } state_e;

  localparam logic [1:0] F_READ  = 2'b00;
  localparam logic [1:0] F_WRITE = 2'b01;
  localparam logic [1:0] F_ALLOC = 2'b10;
  localparam int         CNT_W   = 8;
  localparam logic [ADDR_W-1:0] FREE_RST = ADDR_W'(FREE_BASE);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              alloc_q, alloc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] free_q, free_d;
  logic              full_q, full_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] saddr_q, saddr_d;
  logic [DATA_W-1:0] swdata_q, swdata_d;
  logic              swe_q, swe_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      alloc_q  <= 1'b0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      free_q   <= FREE_RST;
      full_q   <= 1'b0;
      err_q    <= 1'b0;
      saddr_q  <= '0;
      swdata_q <= '0;
      swe_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      alloc_q  <= alloc_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      free_q   <= free_d;
      full_q   <= full_d;
      err_q    <= err_d;
      saddr_q  <= saddr_d;
      swdata_q <= swdata_d;
      swe_q    <= swe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    alloc_d  = alloc_q;
    rdata_d  = rdata_q;
    ready_d  = ready_q;
    free_d   = free_q;
    full_d   = full_q;
    err_d    = err_q;
    saddr_d  = saddr_q;
    swdata_d = swdata_q;
    swe_d    = 1'b0;

    case (state_q)
      S_INIT: begin
        if (cnt_q == CNT_W'(INIT_CYC - 1)) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.execute) begin
          ready_d = 1'b0;
          cnt_d   = '0;
          alloc_d = (bus.func == F_ALLOC);
          case (bus.func)
            F_READ: begin
              saddr_d = bus.address;
              state_d = S_RD_WAIT;
            end
            F_WRITE: begin
              saddr_d  = bus.address;
              swdata_d = bus.write_data;
              swe_d    = 1'b1;
              state_d  = S_WR;
            end
            F_ALLOC: begin
              if (full_q) begin
                err_d   = 1'b1;
                state_d = S_DONE;
              end else begin
                saddr_d  = free_q;
                swdata_d = bus.write_data;
                swe_d    = 1'b1;
                state_d  = S_WR;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      // Address was registered on accept, so the SRAM word is stable one cycle after RD_LAT.
      S_RD_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT)) begin
          rdata_d = sram_rdata_i;
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR: begin
        if (alloc_q) begin
          rdata_d = DATA_W'(free_q);
          if (free_q == '1) begin
            full_d = 1'b1;
          end else begin
            free_d = free_q + 1'b1;
          end
        end
        ready_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        ready_d = 1'b1;
        if (!bus.execute) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.read_data = rdata_q;
  assign bus.is_ready  = ready_q;
  assign free_addr_o   = free_q;
  assign full_o        = full_q;
  assign error_o       = err_q;
  assign state_o       = state_q;
  assign sram_addr_o   = saddr_q;
  assign sram_wdata_o  = swdata_q;
  assign sram_we_o     = swe_q;
endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// +--------------------------------------------------------------------+
// | tb_mem_responder : randomized + directed bench with reference model |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mem_responder;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int RD_LAT = 1;
  localparam int FREE_BASE = 128;
  localparam int INIT_CYC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] free_addr;
  logic          full;
  logic          error;
  logic [3:0]    state;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_we;
  logic [DW-1:0] sram_rdata;

  mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_responder #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT),
    .FREE_BASE(FREE_BASE), .INIT_CYC(INIT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .free_addr_o(free_addr), .full_o(full), .error_o(error), .state_o(state),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_we_o(sram_we),
    .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM with RD_LAT-deep read pipeline plus a backdoor load port
  logic [DW-1:0] sram [1024];
  logic [DW-1:0] pipe [RD_LAT];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) sram[bd_addr] <= bd_data;
    else if (sram_we) sram[sram_addr] <= sram_wdata;
    pipe[0] <= sram[sram_addr];
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign sram_rdata = pipe[RD_LAT-1];

  int we_cnt = 0;
  int we_bad = 0;
  always @(posedge clk) begin
    if (sram_we) we_cnt <= we_cnt + 1;
    if (sram_we && state != 4'd3) we_bad <= we_bad + 1;
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [1024];
  logic [AW-1:0] ref_free;
  logic          ref_full;
  logic          ref_err;
  logic [DW-1:0] ref_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_free = AW'(FREE_BASE);
    ref_full = 1'b0;
    ref_err  = 1'b0;
    ref_rd   = '0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.is_ready && n < 40);
  endtask

  task automatic release_reset();
    int n;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    wait_ready(n);
    check("init_latency", 64'(n), 64'(INIT_CYC));
    check("rst_free_addr", 64'(free_addr), 64'(FREE_BASE));
    check("rst_read_data", bus.read_data, 64'h0);
    check("rst_error_full", {62'h0, error, full}, 64'h0);
  endtask

  task automatic op(input logic [1:0] f, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input int hold);
    int n, we0, exp_we, exp_lat;
    @(negedge clk);
    bus.func = f; bus.address = a; bus.write_data = d; bus.execute = 1'b1;
    we0 = we_cnt;
    wait_ready(n);
    exp_we = 0;
    exp_lat = 2;
    case (f)
      2'b00: begin ref_rd = ref_mem[a]; exp_lat = RD_LAT + 2; end
      2'b01: begin ref_mem[a] = d; exp_we = 1; end
      2'b10: begin
        if (ref_full) ref_err = 1'b1;
        else begin
          ref_rd = 64'(ref_free);
          ref_mem[ref_free] = d;
          exp_we = 1;
          if (ref_free == '1) ref_full = 1'b1;
          else ref_free = ref_free + 1'b1;
        end
      end
      default: ref_err = 1'b1;
    endcase
    check("latency", 64'(n), 64'(exp_lat));
    check("read_data", bus.read_data, ref_rd);
    check("error", 64'(error), 64'(ref_err));
    check("full", 64'(full), 64'(ref_full));
    check("free_addr", 64'(free_addr), 64'(ref_free));
    repeat (hold) @(posedge clk);
    #1;
    check("done_state", 64'(state), 64'd4);
    check("we_pulses", 64'(we_cnt - we0), 64'(exp_we));
    @(negedge clk);
    bus.execute = 1'b0;
    @(posedge clk); #1;
    check("back_idle", {60'h0, state}, 64'd1);
  endtask

  initial begin
    int n, bad;
    bus.func = 2'b00; bus.address = '0; bus.write_data = '0; bus.execute = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = {$urandom, $urandom};
    ref_mem[5] = 64'hDEAD_BEEF;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_addr = AW'(i); bd_data = ref_mem[i];
    end
    @(negedge clk);
    bd_we = 1'b0;
    #1;
    check("rst_state", {59'h0, bus.is_ready, state}, 64'h0);
    check("rst_sram", {sram_addr, 53'h0, sram_we}, 64'h0);
    release_reset();

    // Reset asserted in the middle of a READ
    @(negedge clk);
    bus.func = 2'b00; bus.address = 10'd5; bus.execute = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midread_rst_state", 64'(state), 64'd0);
    check("midread_rst_ready", 64'(bus.is_ready), 64'd0);
    bus.execute = 1'b0;
    release_reset();

    op(2'b00, 10'd5, '0, 0);
    check("dead_beef", bus.read_data, 64'hDEAD_BEEF);
    op(2'b01, 10'd7, 64'h1234, 0);
    op(2'b00, 10'd7, '0, 0);
    check("rd_after_wr", bus.read_data, 64'h1234);

    op(2'b10, '0, 64'hAAAA, 0);
    check("alloc0", bus.read_data, 64'd128);
    op(2'b10, '0, 64'hBBBB, 1);
    check("alloc1", bus.read_data, 64'd129);
    op(2'b10, '0, 64'hCCCC, 0);
    check("alloc2", bus.read_data, 64'd130);
    check("alloc_free", 64'(free_addr), 64'd131);

    for (int i = 0; i < 60; i++) begin
      logic [1:0] f;
      f = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      op(f, AW'($urandom), {$urandom, $urandom}, $urandom_range(0, 3));
    end

    while (ref_free != 10'd1022) op(2'b10, '0, {$urandom, $urandom}, 0);
    op(2'b10, '0, 64'h1111, 0);
    check("alloc_1022", bus.read_data, 64'd1022);
    op(2'b10, '0, 64'h2222, 0);
    check("alloc_1023", bus.read_data, 64'd1023);
    n = we_cnt;
    op(2'b10, '0, 64'h3333, 0);
    check("exhausted", {61'h0, error, full, 1'b0}, 64'h6);
    check("exhausted_free", 64'(free_addr), 64'd1023);
    check("exhausted_no_we", 64'(we_cnt - n), 64'd0);

    @(negedge clk);
    rst_n = 1'b0;
    release_reset();
    n = we_cnt;
    op(2'b11, 10'd9, 64'h5555, 10);
    check("reserved_error", 64'(error), 64'd1);
    check("reserved_no_we", 64'(we_cnt - n), 64'd0);
    n = we_cnt;
    op(2'b01, 10'd9, 64'h7777, 10);
    check("held_done_one_we", 64'(we_cnt - n), 64'd1);
    check("error_sticky", 64'(error), 64'd1);

    bad = 0;
    for (int i = 0; i < 1024; i++) if (sram[i] !== ref_mem[i]) bad++;
    check("sram_contents", 64'(bad), 64'd0);
    check("we_outside_wr", 64'(we_bad), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
